maxpool_ctrl: RTL
=================

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default from cnn_defs.svh (8), meaning pixel width.
REQ-002 SHALL have parameter MAX_COLS, default 64, meaning maximum frame width in pixels (even).
REQ-003 SHALL have parameter DIM_W, default 7, meaning width of the dimension fields (≥ clog2(MAX_COLS)+1).
REQ-004 The clock is clk, in, 1 bit, and is the single clock; all logic is rising-edge.
REQ-005 The reset is rst, in, 1 bit, and is synchronous, active-high.
REQ-006 SHALL have start, in, 1 bit: a one-cycle pulse that latches cfg_cols/cfg_rows and begins a frame.
REQ-007 SHALL have cfg_cols and cfg_rows, in, DIM_W bits each: frame width and height in pixels.
REQ-008 SHALL have in_data, in, DATA_WIDTH bits: raster-order input pixel.
REQ-009 SHALL have in_valid (in, 1) and in_ready (out, 1): input handshake; transfer when both are high.
REQ-010 SHALL have out_data, out, DATA_WIDTH bits: 2x2 max-pooled value.
REQ-011 SHALL have out_valid (out, 1) and out_ready (in, 1): output handshake.
REQ-012 SHALL have out_last, out, 1 bit: high with the final pooled value of the frame.
REQ-013 SHALL have busy, out, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have done, out, 1 bit: one-cycle pulse when the final pooled value is accepted.
REQ-015 SHALL have stall_cnt, out, 16 bits: output back-pressure cycle count (see Configuration).

Function
REQ-016 SHALL instantiate the comparator (4-input unsigned max) for all max computations.
REQ-017 FSM states SHALL be IDLE, EVEN_ROW, ODD_ROW, FLUSH.
REQ-018 In IDLE, a start pulse with cfg_cols[DIM_W-1:1]≠0 and cfg_rows[DIM_W-1:1]≠0 SHALL latch the values with LSB cleared (odd dimensions are rounded down) and enter EVEN_ROW; otherwise start is ignored.
REQ-019 cfg_cols above MAX_COLS SHALL be clamped to MAX_COLS.
REQ-020 In EVEN_ROW, in_ready SHALL be 1; each accepted pixel SHALL be written to line buffer entry col; after col = cols-1 the FSM SHALL go to ODD_ROW.
REQ-021 In ODD_ROW, at even col the accepted pixel SHALL be held in a register; in_ready SHALL be 1.
REQ-022 In ODD_ROW, at odd col, in_ready SHALL be (!out_valid || out_ready).
  - On acceptance, the comparator inputs SHALL be buf[col-1], buf[col], the held pixel and in_data.
  - Its result SHALL load the output register, with out_valid=1 the next cycle (latency 1 cycle from the bottom-right pixel).
REQ-023 The output register SHALL hold out_data/out_valid/out_last stable until out_ready; a same-cycle drain and refill SHALL be allowed (full throughput, no bubble).
REQ-024 After the last pixel of an odd row, the FSM SHALL go to EVEN_ROW if rows remain, else to FLUSH.
REQ-025 out_last SHALL be 1 only on the pooled value for row-pair (rows/2-1), column-pair (cols/2-1).
REQ-026 In FLUSH, when out_valid && out_ready, done SHALL pulse and the FSM SHALL go to IDLE.
REQ-027 in_ready SHALL be 0 in IDLE and FLUSH; in_valid there SHALL be ignored.
REQ-028 start while busy SHALL be ignored; configuration SHALL not change mid-frame.
REQ-029 Column and row counters SHALL wrap to 0 at cols-1 and rows-1 respectively.
REQ-030 Comparisons SHALL be unsigned; ties SHALL produce the equal value.

Reset
REQ-031 On rst=1 at a clock edge:
  - the FSM SHALL go to IDLE;
  - counters SHALL be set to 0;
  - out_valid, out_last, done, busy and in_ready SHALL be 0;
  - out_data SHALL be 0;
  - stall_cnt SHALL be 0.
REQ-032 Reset mid-frame SHALL discard the partial frame and any pending output; line buffer contents need not be cleared.

Configuration
REQ-033 Macro MAXPOOL_STALL_CNT_EN:
  - Defined: stall_cnt SHALL increment each cycle out_valid && !out_ready, saturate at 16'hFFFF, and clear on accepted start.
  - Undefined: stall_cnt SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-034 4x4 frame, pixels 0..15 raster, out_ready=1 -> out_data 5, 7, 13, 15; out_last only on 15; done pulses once.
REQ-035 2x2 frame [200,10;10,200] -> out_data 200, out_last=1; [255,255,255,255] -> 255.
REQ-036 4x2 frame, out_ready held 0 for 5 cycles after the first out_valid -> out_data stable, in_ready=0 at the odd column, stall_cnt=5 (macro defined) or 0 (undefined).
REQ-037 start with cfg_cols=5, cfg_rows=3 -> treated as 4x2: exactly 2 outputs; cfg_cols=1 -> start ignored, busy stays 0.
REQ-038 rst asserted after 6 pixels of a 4x4 frame, then a new 2x2 frame [1,2;3,4] -> single output 4, no stale output.
REQ-039 Back-to-back 64x2 frames with random in_valid and out_ready=1 -> 32 outputs each, matching the reference max model, zero lost or duplicated values.

Source files
------------

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: streaming 2x2 max-pool controller over a raster-order frame.
//
// An even row is stored in a one-row line buffer. The following odd row is
// pooled against it two pixels at a time: the left pixel of each pair is held
// in a register, and the right pixel completes the 2x2 window. The window max
// goes into a single output register that has a ready/valid handshake.
//
// Parameters
//   DATA_WIDTH : pixel width (the default of 8 follows cnn_defs.svh)
//   MAX_COLS   : maximum frame width in pixels (even)
//   DIM_W      : width of the dimension fields (>= clog2(MAX_COLS)+1)
//
// Ports
//   clk, rst             : single rising-edge clock, synchronous active-high reset
//   start                : one-cycle pulse; latches cfg_cols/cfg_rows and begins a frame
//   cfg_cols, cfg_rows   : frame width and height (odd values are rounded down,
//                          and the width is clamped to MAX_COLS)
//   in_data/in_valid/in_ready    : raster-order input pixel stream
//   out_data/out_valid/out_ready : pooled output stream
//   out_last             : marks the final pooled value of the frame
//   busy                 : high whenever the FSM is not idle
//   done                 : one-cycle pulse when the final pooled value is accepted
//   stall_cnt            : count of output back-pressure cycles
//
// Optional feature: define MAXPOOL_STALL_CNT_EN to build the back-pressure
// counter. Without that define, stall_cnt is tied to 0.

// 4-input unsigned max. On a tie it returns the shared value.
module maxpool_max4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);
  logic [W-1:0] m_ab, m_cd;

  always_comb begin
    m_ab = (a >= b) ? a : b;
    m_cd = (c >= d) ? c : d;
    y    = (m_ab >= m_cd) ? m_ab : m_cd;
  end
endmodule

module maxpool_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_COLS   = 64,
  parameter int DIM_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_cols,
  input  logic [DIM_W-1:0]      cfg_rows,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  localparam int AW = (MAX_COLS > 2) ? $clog2(MAX_COLS) : 1;
  localparam logic [DIM_W-1:0] MAX_COLS_D = DIM_W'(MAX_COLS);
  localparam logic [DIM_W-1:0] ONE        = DIM_W'(1);

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, FLUSH} state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]      cols_q, rows_q;
  logic [DIM_W-1:0]      col, row;
  logic [DIM_W-1:0]      cols_clamp;
  logic                  start_ok, in_fire, out_fire, pool_fire;
  logic                  col_end, row_end;
  logic [AW-1:0]         col_idx, col_even;
  logic [DATA_WIDTH-1:0] lbuf [MAX_COLS];
  logic [DATA_WIDTH-1:0] hold_q, pool_max;

  // The start qualification looks at the raw inputs. A width or height below
  // 2 cannot form a single window, so that start is dropped.
  always_comb begin
    cols_clamp = (cfg_cols > MAX_COLS_D) ? MAX_COLS_D : cfg_cols;
    start_ok   = (state == IDLE) && start &&
                 (cfg_cols[DIM_W-1:1] != '0) && (cfg_rows[DIM_W-1:1] != '0);
    col_end    = (col == cols_q - ONE);
    row_end    = (row == rows_q - ONE);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    pool_fire  = in_fire && (state == ODD_ROW) && col[0];
    col_idx    = col[AW-1:0];
    col_even   = col_idx & ~AW'(1);
  end

  // When the bottom-right pixel is accepted, the window is
  // buf[col-1], buf[col], the held bottom-left pixel and the live pixel.
  maxpool_max4 #(.W(DATA_WIDTH)) u_max4 (
    .a (lbuf[col_even]),
    .b (lbuf[col_idx]),
    .c (hold_q),
    .d (in_data),
    .y (pool_max)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_ok)           state_nxt = EVEN_ROW;
      EVEN_ROW: if (in_fire && col_end) state_nxt = ODD_ROW;
      ODD_ROW:  if (in_fire && col_end) state_nxt = row_end ? FLUSH : EVEN_ROW;
      FLUSH:    if (out_fire)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. At the right pixel of a pair, the input is only taken when
  // the output register can drain in the same cycle. This gives full
  // throughput and never drops a pooled value.
  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      EVEN_ROW: in_ready = 1'b1;
      ODD_ROW:  in_ready = col[0] ? (!out_valid || out_ready) : 1'b1;
      FLUSH:    done     = out_fire;
      default:  ;
    endcase
  end

  // Counters, held pixel and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q    <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      hold_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (start_ok) begin
        cols_q <= cols_clamp & ~ONE;
        rows_q <= cfg_rows & ~ONE;
        col    <= '0;
        row    <= '0;
      end
      if (in_fire) begin
        col <= col_end ? '0 : col + ONE;
        if (col_end) row <= row_end ? '0 : row + ONE;
      end
      if (in_fire && (state == ODD_ROW) && !col[0]) hold_q <= in_data;
      if (pool_fire) begin
        out_valid <= 1'b1;
        out_data  <= pool_max;
        out_last  <= row_end && col_end;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Line buffer: holds the even row. Reset does not clear it, because every
  // entry is rewritten before it is read again.
  always_ff @(posedge clk) begin
    if (in_fire && (state == EVEN_ROW)) lbuf[col_idx] <= in_data;
  end

`ifdef MAXPOOL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (start_ok)
      stall_q <= '0;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
